// File: rtl/rf_wb_arbiter_if.sv
// -----------------------------------------------------------------------------
// rf_wb_arbiter_if
//   Writeback request bundle between the NREQ producers and the register-file
//   write arbiter. Each lane i is a valid/ready channel carrying a destination
//   register and the data to write.
//
//   Signals (packed, lane i at [i*W +: W]):
//     req_valid [NREQ]       producer -> arbiter   write request
//     req_addr  [NREQ*AW]    producer -> arbiter   destination register
//     req_data  [NREQ*XLEN]  producer -> arbiter   write data
//     req_ready [NREQ]       arbiter  -> producer  grant (transfer on valid&&ready)
//
//   Modports: master = producer side, slave = arbiter side.
// -----------------------------------------------------------------------------
interface rf_wb_arbiter_if #(
  parameter int NREQ = 2,
  parameter int XLEN = 64,
  parameter int AW   = 5
);

  logic [NREQ-1:0]      req_valid;
  logic [NREQ*AW-1:0]   req_addr;
  logic [NREQ*XLEN-1:0] req_data;
  logic [NREQ-1:0]      req_ready;

  modport master (
    output req_valid,
    output req_addr,
    output req_data,
    input  req_ready
  );

  modport slave (
    input  req_valid,
    input  req_addr,
    input  req_data,
    output req_ready
  );

endinterface : rf_wb_arbiter_if

// File: rtl/rf_wb_arbiter.sv
// -----------------------------------------------------------------------------
// rf_wb_arbiter
//   Owns the single write port of the 32 x XLEN integer register file.
//   - Round-robin arbitration between NREQ writeback producers.
//   - The winning write is registered onto the regfile write port; the regfile
//     samples that port on the falling edge inside the following cycle.
//   - A busy scoreboard of destinations with outstanding writes lets the issue
//     stage stall RAW/WAW hazards.
//
//   Ports:
//     clk        system clock
//     rst_n      asynchronous active-low reset
//     wb         writeback request bundle (slave side)
//     rf_we      regfile write enable   (WE)
//     rf_waddr   regfile write address  (A3)
//     rf_wdata   regfile write data     (WD)
//     iss_valid  issue stage dispatching an instruction that writes iss_rd
//     iss_rd     destination of the issuing instruction
//     iss_ready  issue permitted (destination not busy)
//     sb_busy    scoreboard, bit r = write to xr outstanding (bit 0 always 0)
// -----------------------------------------------------------------------------
module rf_wb_arbiter #(
  parameter int NREQ = 2,
  parameter int XLEN = 64,
  parameter int AW   = 5
) (
  input  logic             clk,
  input  logic             rst_n,

  rf_wb_arbiter_if.slave   wb,

  output logic             rf_we,
  output logic [AW-1:0]    rf_waddr,
  output logic [XLEN-1:0]  rf_wdata,

  input  logic             iss_valid,
  input  logic [AW-1:0]    iss_rd,
  output logic             iss_ready,
  output logic [31:0]      sb_busy
);

  localparam int PW   = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int NREG = 32;

  // Pointer to the most recent winner; priority starts just after it.
  logic [PW-1:0]   last_grant;

  logic            grant_any;
  logic [PW-1:0]   grant_idx;
  logic [AW-1:0]   grant_addr;
  logic [XLEN-1:0] grant_data;

  logic            issue_set;
  logic [NREG-1:0] sb_next;
  // x0 is never tracked, so only bits 31..1 are real state.
  logic [NREG-1:1] sb_q;

  // ---------------------------------------------------------------------------
  // Round-robin arbitration. Scan starts at last_grant+1 and wraps; the first
  // valid lane wins. Only req_valid feeds the grant so address/data timing
  // never reaches req_ready.
  // ---------------------------------------------------------------------------
  always_comb begin : arbitrate
    int idx;
    // NOTE: every variable driven here gets a default before any condition,
    // otherwise a path that skips the assignment infers a latch.
    grant_any  = 1'b0;
    grant_idx  = '0;
    grant_addr = '0;
    grant_data = '0;
    idx        = 0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = (int'(last_grant) + k) % NREQ;
      if (!grant_any && wb.req_valid[idx]) begin
        grant_any  = 1'b1;
        grant_idx  = PW'(idx);
        grant_addr = wb.req_addr[idx*AW +: AW];
        grant_data = wb.req_data[idx*XLEN +: XLEN];
      end
    end
  end

  // One-hot grant; the output register drains every cycle so the grant is the
  // only backpressure a producer ever sees.
  always_comb begin
    wb.req_ready = '0;
    for (int i = 0; i < NREQ; i++) begin
      wb.req_ready[i] = grant_any && (grant_idx == PW'(i));
    end
  end

  // ---------------------------------------------------------------------------
  // Scoreboard
  // ---------------------------------------------------------------------------
  assign sb_busy   = {sb_q, 1'b0};
  assign iss_ready = (iss_rd == '0) || !sb_busy[iss_rd];
  assign issue_set = iss_valid && iss_ready && (iss_rd != '0);

  // The clear is applied first so a same-index set in the same edge wins.
  always_comb begin
    sb_next = sb_busy;
    if (rf_we) begin
      sb_next[rf_waddr] = 1'b0;
    end
    if (issue_set) begin
      sb_next[iss_rd] = 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Output register, pointer and scoreboard state.
  // A write to x0 is consumed (pointer moves, data latched) but never enables
  // the regfile, so it neither writes nor clears the scoreboard.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: state is updated with non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    if (!rst_n) begin
      rf_we      <= 1'b0;
      rf_waddr   <= '0;
      rf_wdata   <= '0;
      last_grant <= PW'(NREQ - 1);
      sb_q       <= '0;
    end else begin
      rf_we <= grant_any && (grant_addr != '0);
      if (grant_any) begin
        rf_waddr   <= grant_addr;
        rf_wdata   <= grant_data;
        last_grant <= grant_idx;
      end
      sb_q <= sb_next[NREG-1:1];
    end
  end

endmodule : rf_wb_arbiter

// File: tb/tb_rf_wb_arbiter.sv
// -----------------------------------------------------------------------------
// tb_rf_wb_arbiter
//   Directed scenarios followed by randomized traffic, all compared against a
//   transaction-level reference model of the arbiter, write port and scoreboard.
// -----------------------------------------------------------------------------
module tb_rf_wb_arbiter;

  localparam int NREQ = 2;
  localparam int XLEN = 64;
  localparam int AW   = 5;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            iss_valid;
  logic [AW-1:0]   iss_rd;
  logic            iss_ready;
  logic            rf_we;
  logic [AW-1:0]   rf_waddr;
  logic [XLEN-1:0] rf_wdata;
  logic [31:0]     sb_busy;

  // Bench-side request lanes.
  logic            tv [NREQ];
  logic [AW-1:0]   ta [NREQ];
  logic [XLEN-1:0] td [NREQ];

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state.
  int              m_last;
  bit              m_we;
  bit [AW-1:0]     m_waddr;
  bit [XLEN-1:0]   m_wdata;
  bit [31:0]       m_sb;

  rf_wb_arbiter_if #(.NREQ(NREQ), .XLEN(XLEN), .AW(AW)) wb ();

  for (genvar g = 0; g < NREQ; g++) begin : g_pack
    assign wb.req_valid[g]               = tv[g];
    assign wb.req_addr[g*AW +: AW]       = ta[g];
    assign wb.req_data[g*XLEN +: XLEN]   = td[g];
  end

  rf_wb_arbiter #(.NREQ(NREQ), .XLEN(XLEN), .AW(AW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .wb        (wb),
    .rf_we     (rf_we),
    .rf_waddr  (rf_waddr),
    .rf_wdata  (rf_wdata),
    .iss_valid (iss_valid),
    .iss_rd    (iss_rd),
    .iss_ready (iss_ready),
    .sb_busy   (sb_busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic set_idle();
    for (int i = 0; i < NREQ; i++) begin
      tv[i] = 1'b0;
      ta[i] = '0;
      td[i] = '0;
    end
    iss_valid = 1'b0;
    iss_rd    = '0;
  endtask

  task automatic model_reset();
    m_last  = NREQ - 1;
    m_we    = 1'b0;
    m_waddr = '0;
    m_wdata = '0;
    m_sb    = '0;
  endtask

  // Round-robin rule: first valid requester after the previous winner.
  function automatic int pick_winner();
    for (int k = 1; k <= NREQ; k++) begin
      int i;
      i = (m_last + k) % NREQ;
      if (tv[i]) return i;
    end
    return -1;
  endfunction

  task automatic check_regs();
    check("rf_we",    64'(rf_we),    64'(m_we));
    check("rf_waddr", 64'(rf_waddr), 64'(m_waddr));
    check("rf_wdata", rf_wdata,      m_wdata);
    check("sb_busy",  64'(sb_busy),  64'(m_sb));
  endtask

  // Called at a negedge with inputs already applied. Checks the combinational
  // outputs, advances the model across one posedge and checks the registers.
  task automatic run_cycle();
    int            w;
    bit [NREQ-1:0] exp_ready;
    bit            exp_iss_ready;
    bit [31:0]     nsb;
    #1;
    w         = pick_winner();
    exp_ready = '0;
    if (w >= 0) exp_ready[w] = 1'b1;
    exp_iss_ready = (iss_rd == 0) || !m_sb[iss_rd];
    check("req_ready", 64'(wb.req_ready), 64'(exp_ready));
    check("iss_ready", 64'(iss_ready),    64'(exp_iss_ready));

    nsb = m_sb;
    if (m_we) nsb[m_waddr] = 1'b0;
    if (iss_valid && exp_iss_ready && iss_rd != 0) nsb[iss_rd] = 1'b1;
    if (w >= 0) begin
      m_we    = (ta[w] != 0);
      m_waddr = ta[w];
      m_wdata = td[w];
      m_last  = w;
    end else begin
      m_we = 1'b0;
    end
    m_sb = nsb;

    @(posedge clk);
    #1;
    check_regs();
    @(negedge clk);
  endtask

  initial begin : main
    bit [NREQ-1:0] rr_exp [8];

    // ---------------- reset state ----------------
    set_idle();
    rst_n = 1'b0;
    model_reset();
    #1;
    check_regs();
    check("reset_ready", 64'(wb.req_ready), 64'(0));
    @(posedge clk);
    #1;
    check_regs();
    @(negedge clk);
    rst_n = 1'b1;

    // ---------------- round robin ----------------
    rr_exp = '{2'b01, 2'b10, 2'b01, 2'b10, 2'b10, 2'b10, 2'b10, 2'b01};
    for (int c = 0; c < 8; c++) begin
      tv[0] = (c < 4) || (c == 7);
      tv[1] = 1'b1;
      ta[0] = 5'd1;  td[0] = 64'h100 + 64'(c);
      ta[1] = 5'd2;  td[1] = 64'h200 + 64'(c);
      #1;
      check("rr_seq", 64'(wb.req_ready), 64'(rr_exp[c]));
      run_cycle();
    end
    set_idle();
    run_cycle();

    // ---------------- single write latency ----------------
    tv[1] = 1'b1; ta[1] = 5'd7; td[1] = 64'h1234;
    #1;
    check("single_ready", 64'(wb.req_ready), 64'(2'b10));
    run_cycle();
    check("single_we",    64'(rf_we),    64'(1));
    check("single_waddr", 64'(rf_waddr), 64'(7));
    check("single_wdata", rf_wdata,      64'h1234);
    set_idle();
    run_cycle();
    check("single_we_off", 64'(rf_we), 64'(0));

    // ---------------- x0 filter ----------------
    tv[0] = 1'b1; ta[0] = 5'd0; td[0] = 64'hFFFF;
    #1;
    check("x0_ready", 64'(wb.req_ready), 64'(2'b01));
    run_cycle();
    check("x0_we", 64'(rf_we), 64'(0));
    set_idle();
    run_cycle();

    // ---------------- scoreboard stall ----------------
    iss_valid = 1'b1; iss_rd = 5'd3;
    run_cycle();
    check("sb3_set", 64'(sb_busy[3]), 64'(1));
    for (int c = 0; c < 2; c++) begin
      #1;
      check("sb3_stall", 64'(iss_ready), 64'(0));
      run_cycle();
    end
    iss_rd = 5'd0;
    #1;
    check("x0_iss_ready", 64'(iss_ready), 64'(1));
    run_cycle();
    // Writeback of x3: accepted, then rf_we for one cycle, cleared at its end.
    iss_valid = 1'b0; iss_rd = 5'd3;
    tv[0] = 1'b1; ta[0] = 5'd3; td[0] = 64'h33;
    run_cycle();
    tv[0] = 1'b0;
    #1;
    check("sb3_wb_pending", 64'(iss_ready), 64'(0));
    run_cycle();
    check("sb3_cleared", 64'(sb_busy[3]), 64'(0));
    check("sb3_ready", 64'(iss_ready), 64'(1));

    // ---------------- set/clear collision ----------------
    set_idle();
    tv[0] = 1'b1; ta[0] = 5'd9; td[0] = 64'h99;
    run_cycle();
    set_idle();
    iss_valid = 1'b1; iss_rd = 5'd9;
    #1;
    check("coll_we", 64'(rf_we), 64'(1));
    run_cycle();
    check("coll_sb9", 64'(sb_busy[9]), 64'(1));
    set_idle();

    // ---------------- reset mid-write ----------------
    tv[0] = 1'b1; ta[0] = 5'd5; td[0] = 64'hAA;
    run_cycle();
    check("mid_we_before", 64'(rf_we), 64'(1));
    set_idle();
    rst_n = 1'b0;
    model_reset();
    #1;
    check("mid_we_reset", 64'(rf_we), 64'(0));
    check_regs();
    @(posedge clk);
    #1;
    check_regs();
    @(negedge clk);
    rst_n = 1'b1;

    // ---------------- randomized traffic ----------------
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < NREQ; i++) begin
        tv[i] = 1'($urandom_range(0, 1));
        ta[i] = AW'($urandom_range(0, 7));
        td[i] = {$urandom, $urandom};
      end
      iss_valid = 1'($urandom_range(0, 1));
      iss_rd    = AW'($urandom_range(0, 7));
      run_cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_rf_wb_arbiter

// File: doc/rf_wb_arbiter.md
Name: rf_wb_arbiter

Overview:
- Sequences the single write port of the 32x64 integer register file.
- Arbitrates round-robin between NREQ writeback producers (e.g. ALU path, LSU/multi-cycle unit) using valid/ready handshakes.
- Registers the winning write onto the register-file write port.
- Maintains a busy scoreboard of destination registers with outstanding writes, which the issue stage uses to stall RAW/WAW hazards.

Parameters:
- NREQ, 2, number of writeback requesters (2..4)
- XLEN, 64, data width
- AW, 5, register address width

Ports:
- clk  input  1  system clock; regfile samples the write port on negedge clk
- rst_n  input  1  asynchronous active-low reset
- req_valid  input  NREQ  per-requester write request
- req_addr  input  NREQ*AW  destination register; requester i uses bits [i*AW +: AW]
- req_data  input  NREQ*XLEN  write data; requester i uses bits [i*XLEN +: XLEN]
- req_ready  output  NREQ  grant; a transfer occurs when req_valid[i] && req_ready[i] at posedge clk
- rf_we  output  1  register-file write enable (drives WE)
- rf_waddr  output  AW  register-file write address (drives A3)
- rf_wdata  output  XLEN  register-file write data (drives WD)
- iss_valid  input  1  issue stage wants to dispatch an instruction writing iss_rd
- iss_rd  input  AW  destination of the issuing instruction
- iss_ready  output  1  issue permitted (destination not busy)
- sb_busy  output  32  scoreboard vector; bit r = write to xr outstanding

Behaviour:
- Reset (async, rst_n low): rf_we=0, rf_waddr=0, rf_wdata=0, sb_busy=0, round-robin pointer set so requester 0 has highest priority. Any write held in the output register is dropped; no regfile write occurs. Outputs stay at reset values until the first posedge after rst_n rises.
- Arbitration (combinational):
  - Priority starts at (last_grant+1) mod NREQ and wraps.
  - Exactly one req_ready bit is high when any req_valid is high; req_ready=0 when none are valid.
  - req_ready does not depend on req_addr or req_data.
  - The output register drains every cycle, so no backpressure is applied beyond arbitration.
- Pointer update: on every accepted transfer, last_grant <= granted index. Idle cycles leave the pointer unchanged.
- Output register (posedge clk):
  - On transfer, rf_waddr <= addr and rf_wdata <= data.
  - rf_we <= (addr != 0).
  - Without a transfer, rf_we <= 0 and rf_waddr/rf_wdata hold their previous values.
  - Latency: a request accepted at edge N drives rf_we high from N to N+1. The regfile commits it at the negedge inside that cycle. rf_we is never high for more than one cycle per transfer.
- x0 writes: accepted and consumed (req_ready high as normal), but rf_we stays 0 and the scoreboard is untouched.
- Scoreboard (posedge clk):
  - iss_ready = (iss_rd == 0) || !sb_busy[iss_rd] (combinational).
  - Set: iss_valid && iss_ready && iss_rd != 0 sets sb_busy[iss_rd].
  - Clear: at the edge ending a cycle with rf_we=1, sb_busy[rf_waddr] is cleared.
  - Set and clear on the same index in the same edge: set wins.
  - sb_busy[0] is constant 0.
- Writeback to a non-busy register (producer not tracked): the write is performed; the clear is a no-op.
- Simultaneous requests with identical addresses: serviced one per cycle in round-robin order; the last granted one wins in the regfile.

Test Plan:
- Reset mid-write: req_valid[0]=1, addr=5, data=0xAA accepted at edge N; assert rst_n low before edge N+1 -> rf_we drops to 0 immediately; sb_busy=0; reg x5 unchanged.
- Single write latency: req_valid[1]=1, addr=7, data=0x1234 at edge N -> req_ready=2'b10 before edge N; rf_we=1, rf_waddr=7, rf_wdata=0x1234 during cycle N+1; rf_we=0 during cycle N+2.
- Round-robin: both requesters valid continuously for 4 cycles after reset -> grants 0,1,0,1. Then only req 1 valid -> granted every cycle. Then both valid -> req 0 next.
- x0 filter: req addr=0, data=0xFFFF -> req_ready=1, rf_we stays 0, sb_busy unchanged.
- Scoreboard stall: issue x3 (iss_valid=1, iss_rd=3) -> sb_busy[3]=1 next cycle. Second issue of rd=3 -> iss_ready=0 until the writeback of x3 completes. iss_ready=1 for iss_rd=0 at all times.
- Set/clear collision: rf_we=1, rf_waddr=9 in the same cycle as an issue of rd=9 -> after the edge, sb_busy[9]=1.
